// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the 640x480@60 VGA raster generator.
// Defaults describe the standard mode; derived values are handy for integrators.
package vga_timing_pkg;

   localparam int CNT_W = 10;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;
   localparam int PIPE_LAT_DEF = 2;
   localparam logic SYNC_ACT_DEF = 1'b0;

   localparam int H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
   localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
   localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
   localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
   localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

   // Control bits that travel alongside the pixel through the return pipeline.
   typedef struct packed {
      logic act;
      logic hs;
      logic vs;
   } vga_ctl_t;

endpackage

// File: rtl/vga_sync_delay.sv
// N-deep, W-wide shift register with synchronous clear; aligns raster
// control bits with pixels returning from the upstream read path.
module vga_sync_delay
   import vga_timing_pkg::*;
#(
   parameter int N = 2,
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         clr_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] sr_q [N];

   always_ff @(posedge clk) begin
      if (clr_i) begin
         for (int i = 0; i < N; i++) sr_q[i] <= '0;
      end else begin
         sr_q[0] <= d_i;
         for (int i = 1; i < N; i++) sr_q[i] <= sr_q[i-1];
      end
   end

   assign q_o = sr_q[N-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: counts the raster, requests pixels upstream and
// drives the DAC with sync/blank/RGB aligned to the returned pixel data.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE = H_ACTIVE_DEF,
   parameter int   H_FP     = H_FP_DEF,
   parameter int   H_SYNC   = H_SYNC_DEF,
   parameter int   H_BP     = H_BP_DEF,
   parameter int   V_ACTIVE = V_ACTIVE_DEF,
   parameter int   V_FP     = V_FP_DEF,
   parameter int   V_SYNC   = V_SYNC_DEF,
   parameter int   V_BP     = V_BP_DEF,
   parameter logic SYNC_ACT = SYNC_ACT_DEF,
   parameter int   PIPE_LAT = PIPE_LAT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pll_locked,
   output logic             pix_req,
   output logic [CNT_W-1:0] pix_x,
   output logic [CNT_W-1:0] pix_y,
   input  logic [7:0]       pix_r,
   input  logic [7:0]       pix_g,
   input  logic [7:0]       pix_b,
   output logic             vga_hs,
   output logic             vga_vs,
   output logic             vga_blank_n,
   output logic             vga_sync_n,
   output logic [7:0]       vga_r,
   output logic [7:0]       vga_g,
   output logic [7:0]       vga_b,
   output logic             frame_start,
   output logic             line_start
);

   localparam int CW1      = CNT_W + 1;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int VS_START = V_ACTIVE + V_FP;

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W:0]   H_ACT_C    = CW1'(H_ACTIVE);
   localparam logic [CNT_W:0]   V_ACT_C    = CW1'(V_ACTIVE);
   localparam logic [CNT_W:0]   HS_START_C = CW1'(HS_START);
   localparam logic [CNT_W:0]   HS_END_C   = CW1'(HS_START + H_SYNC);
   localparam logic [CNT_W:0]   VS_START_C = CW1'(VS_START);
   localparam logic [CNT_W:0]   VS_END_C   = CW1'(VS_START + V_SYNC);

   if (PIPE_LAT < 1 || PIPE_LAT > 8) begin : g_bad_pipe_lat
      $error("vga_timing_gen: PIPE_LAT must be within 1..8");
   end
   if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
      $error("vga_timing_gen: H/V totals exceed the counter width");
   end

   logic             lock_meta_q, lock_s_q, run;
   logic             cnt_vld_q;
   logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [CNT_W:0]   h_ext, v_ext;
   logic             active_raw, hs_raw, vs_raw;
   vga_ctl_t         req_ctl_q, dly_ctl;
   logic [2:0]       dly_bits;
   logic [CNT_W-1:0] pix_x_q, pix_y_q;
   logic             frame_start_q, line_start_q;
   logic             vga_hs_q, vga_vs_q, vga_blank_n_q;
   logic [7:0]       vga_r_q, vga_g_q, vga_b_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
      end else begin
         lock_meta_q <= pll_locked;
         lock_s_q    <= lock_meta_q;
      end
   end

   assign run   = rst_n & lock_s_q;
   assign h_ext = {1'b0, h_cnt_q};
   assign v_ext = {1'b0, v_cnt_q};

   // cnt_vld_q marks the first clock of a run so counting starts from 0,0
   assign active_raw = cnt_vld_q && (h_ext < H_ACT_C) && (v_ext < V_ACT_C);
   assign hs_raw     = (h_ext >= HS_START_C) && (h_ext < HS_END_C);
   assign vs_raw     = (v_ext >= VS_START_C) && (v_ext < VS_END_C);

   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (cnt_vld_q) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
         end else begin
            h_cnt_d = h_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!run) begin
         cnt_vld_q     <= 1'b0;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         req_ctl_q     <= '0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         frame_start_q <= 1'b0;
         line_start_q  <= 1'b0;
      end else begin
         cnt_vld_q     <= 1'b1;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         req_ctl_q     <= '{act: active_raw, hs: hs_raw, vs: vs_raw};
         pix_x_q       <= active_raw ? h_cnt_q : '0;
         pix_y_q       <= active_raw ? v_cnt_q : '0;
         frame_start_q <= active_raw && (h_cnt_q == '0) && (v_cnt_q == '0);
         line_start_q  <= active_raw && (h_cnt_q == '0);
      end
   end

   vga_sync_delay #(
      .N (PIPE_LAT),
      .W (3)
   ) u_sync_delay (
      .clk   (clk),
      .clr_i (~run),
      .d_i   (req_ctl_q),
      .q_o   (dly_bits)
   );

   assign dly_ctl = vga_ctl_t'(dly_bits);

   always_ff @(posedge clk) begin
      if (!run) begin
         vga_hs_q      <= ~SYNC_ACT;
         vga_vs_q      <= ~SYNC_ACT;
         vga_blank_n_q <= 1'b0;
         vga_r_q       <= '0;
         vga_g_q       <= '0;
         vga_b_q       <= '0;
      end else begin
         vga_hs_q      <= dly_ctl.hs ? SYNC_ACT : ~SYNC_ACT;
         vga_vs_q      <= dly_ctl.vs ? SYNC_ACT : ~SYNC_ACT;
         vga_blank_n_q <= dly_ctl.act;
         vga_r_q       <= dly_ctl.act ? pix_r : '0;
         vga_g_q       <= dly_ctl.act ? pix_g : '0;
         vga_b_q       <= dly_ctl.act ? pix_b : '0;
      end
   end

   assign pix_req     = req_ctl_q.act;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign frame_start = frame_start_q;
   assign line_start  = line_start_q;
   assign vga_hs      = vga_hs_q;
   assign vga_vs      = vga_vs_q;
   assign vga_blank_n = vga_blank_n_q;
   assign vga_sync_n  = 1'b0;
   assign vga_r       = vga_r_q;
   assign vga_g       = vga_g_q;
   assign vga_b       = vga_b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a 640x480 instance for start-up, line timing and alignment,
// plus a tiny-geometry instance so whole frames and wraps fit in a short run.
`timescale 1ns/1ps
module tb_vga_timing_gen;

   typedef struct packed {
      int ha; int hfp; int hsy; int hbp;
      int va; int vfp; int vsy; int vbp;
   } geom_t;

   localparam geom_t G_D = '{ha: 640, hfp: 16, hsy: 96, hbp: 48, va: 480, vfp: 10, vsy: 2, vbp: 33};
   localparam geom_t G_S = '{ha: 8, hfp: 2, hsy: 3, hbp: 2, va: 6, vfp: 1, vsy: 2, vbp: 2};
   localparam logic [26:0] IDLE_DAC = {1'b0, 1'b1, 1'b1, 24'd0};

   logic clk = 1'b0;
   logic rst_n, pll_locked;
   int   checks = 0;
   int   errors = 0;
   int   ncyc = 0;
   int   t0 = 0;

   logic       d_pix_req, d_fs, d_ls, d_hs, d_vs, d_blank_n, d_sync_n;
   logic [9:0] d_pix_x, d_pix_y, d_x1, d_x2, d_y1, d_y2;
   logic [7:0] d_r, d_g, d_b;
   logic       s_pix_req, s_fs, s_ls, s_hs, s_vs, s_blank_n, s_sync_n;
   logic [9:0] s_pix_x, s_pix_y, s_x1, s_x2, s_y1, s_y2;
   logic [7:0] s_r, s_g, s_b;
   logic [22:0] d_req_v, s_req_v;
   logic [26:0] d_dac_v, s_dac_v;

   always #20 clk = ~clk;

   initial begin
      d_x1 = '0; d_x2 = '0; d_y1 = '0; d_y2 = '0;
      s_x1 = '0; s_x2 = '0; s_y1 = '0; s_y2 = '0;
   end

   // upstream read path: returns {x, y, A5} two clocks after each request
   always @(posedge clk) begin
      d_x1 <= d_pix_x; d_x2 <= d_x1; d_y1 <= d_pix_y; d_y2 <= d_y1;
      s_x1 <= s_pix_x; s_x2 <= s_x1; s_y1 <= s_pix_y; s_y2 <= s_y1;
   end

   vga_timing_gen dut (
      .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
      .pix_req(d_pix_req), .pix_x(d_pix_x), .pix_y(d_pix_y),
      .pix_r(d_x2[7:0]), .pix_g(d_y2[7:0]), .pix_b(8'hA5),
      .vga_hs(d_hs), .vga_vs(d_vs), .vga_blank_n(d_blank_n), .vga_sync_n(d_sync_n),
      .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
      .frame_start(d_fs), .line_start(d_ls)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
   ) dut_s (
      .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
      .pix_req(s_pix_req), .pix_x(s_pix_x), .pix_y(s_pix_y),
      .pix_r(s_x2[7:0]), .pix_g(s_y2[7:0]), .pix_b(8'hA5),
      .vga_hs(s_hs), .vga_vs(s_vs), .vga_blank_n(s_blank_n), .vga_sync_n(s_sync_n),
      .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
      .frame_start(s_fs), .line_start(s_ls)
   );

   assign d_req_v = {d_pix_req, d_pix_x, d_pix_y, d_fs, d_ls};
   assign s_req_v = {s_pix_req, s_pix_x, s_pix_y, s_fs, s_ls};
   assign d_dac_v = {d_blank_n, d_hs, d_vs, d_r, d_g, d_b};
   assign s_dac_v = {s_blank_n, s_hs, s_vs, s_r, s_g, s_b};

   // d = clocks since lock (or reset release) became visible to the DUT input
   function automatic logic [22:0] exp_req(geom_t g, int d);
      int ht, ft, p, h, v;
      logic act;
      logic [9:0] hx, vy;
      ht = g.ha + g.hfp + g.hsy + g.hbp;
      ft = ht * (g.va + g.vfp + g.vsy + g.vbp);
      if (d < 4) return 23'd0;
      p = (d - 4) % ft;
      h = p % ht;
      v = p / ht;
      act = (h < g.ha) && (v < g.va);
      hx = act ? 10'(h) : 10'd0;
      vy = act ? 10'(v) : 10'd0;
      return {act, hx, vy, act && (h == 0) && (v == 0), act && (h == 0)};
   endfunction

   function automatic logic [26:0] exp_dac(geom_t g, int d);
      int ht, ft, p, h, v;
      logic act, hsy, vsy;
      logic [7:0] r, gg, b;
      ht = g.ha + g.hfp + g.hsy + g.hbp;
      ft = ht * (g.va + g.vfp + g.vsy + g.vbp);
      if (d < 7) return IDLE_DAC;
      p = (d - 7) % ft;
      h = p % ht;
      v = p / ht;
      act = (h < g.ha) && (v < g.va);
      hsy = (h >= g.ha + g.hfp) && (h < g.ha + g.hfp + g.hsy);
      vsy = (v >= g.va + g.vfp) && (v < g.va + g.vfp + g.vsy);
      r  = act ? 8'(h) : 8'd0;
      gg = act ? 8'(v) : 8'd0;
      b  = act ? 8'hA5 : 8'd0;
      return {act, ~hsy, ~vsy, r, gg, b};
   endfunction

   task automatic tick();
      @(negedge clk);
      ncyc++;
   endtask

   task automatic test_reset();
      int bad;
      rst_n = 1'b0;
      pll_locked = 1'b1;
      repeat (10) tick();
      checks++;
      if (d_req_v !== 23'd0) begin
         errors++; $display("FAIL reset_req: got %h expected %h", d_req_v, 23'd0);
      end
      checks++;
      if ({d_dac_v, d_sync_n} !== {IDLE_DAC, 1'b0}) begin
         errors++; $display("FAIL reset_dac: got %h expected %h", {d_dac_v, d_sync_n}, {IDLE_DAC, 1'b0});
      end
      checks++;
      if ({s_req_v, s_dac_v} !== {23'd0, IDLE_DAC}) begin
         errors++; $display("FAIL reset_small: got %h expected %h", {s_req_v, s_dac_v}, {23'd0, IDLE_DAC});
      end
      rst_n = 1'b1;
      pll_locked = 1'b0;
      bad = 0;
      repeat (10) begin
         tick();
         if (d_req_v !== 23'd0 || d_dac_v !== IDLE_DAC) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL unlocked_idle: got %0d active cycles expected 0", bad);
      end
   endtask

   task automatic test_startup();
      int first_req, first_blank, s_first;
      logic [21:0] req_seen;
      logic [23:0] rgb_seen;
      logic s_fs_seen;
      first_req = -1; first_blank = -1; s_first = -1;
      req_seen = '0; rgb_seen = '0; s_fs_seen = 1'b0;
      pll_locked = 1'b1;
      t0 = ncyc;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (first_req < 0 && d_pix_req === 1'b1) begin
            first_req = ncyc - t0;
            req_seen = {d_pix_x, d_pix_y, d_fs, d_ls};
         end
         if (first_blank < 0 && d_blank_n === 1'b1) begin
            first_blank = ncyc - t0;
            rgb_seen = {d_r, d_g, d_b};
         end
         if (s_first < 0 && s_pix_req === 1'b1) begin
            s_first = ncyc - t0;
            s_fs_seen = s_fs;
         end
      end
      checks++;
      if (first_req !== 4) begin
         errors++; $display("FAIL startup_req_latency: got %0d expected 4", first_req);
      end
      checks++;
      if (req_seen !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
         errors++; $display("FAIL startup_first_req: got %h expected %h", req_seen, {10'd0, 10'd0, 1'b1, 1'b1});
      end
      checks++;
      if (first_blank !== 7) begin
         errors++; $display("FAIL startup_blank_latency: got %0d expected 7", first_blank);
      end
      checks++;
      if (rgb_seen !== {8'd0, 8'd0, 8'hA5}) begin
         errors++; $display("FAIL startup_first_rgb: got %h expected %h", rgb_seen, {8'd0, 8'd0, 8'hA5});
      end
      checks++;
      if (s_first !== 4 || s_fs_seen !== 1'b1) begin
         errors++; $display("FAIL startup_small: got %0d/%b expected 4/1", s_first, s_fs_seen);
      end
   endtask

   task automatic test_line_timing();
      int blank_rise, blank_rise2, fall1, fall2, rise1, blank_cnt, vs_low;
      logic prev_hs, prev_blank;
      blank_rise = -1; blank_rise2 = -1; fall1 = -1; fall2 = -1; rise1 = -1;
      blank_cnt = 0; vs_low = 0;
      prev_hs = d_hs; prev_blank = d_blank_n;
      repeat (2500) begin
         tick();
         if (d_blank_n === 1'b1 && prev_blank === 1'b0) begin
            if (blank_rise < 0) blank_rise = ncyc - t0;
            else if (blank_rise2 < 0) blank_rise2 = ncyc - t0;
         end
         if (blank_rise >= 0 && d_hs === 1'b0 && prev_hs === 1'b1) begin
            if (fall1 < 0) fall1 = ncyc - t0;
            else if (fall2 < 0) fall2 = ncyc - t0;
         end
         if (fall1 >= 0 && rise1 < 0 && d_hs === 1'b1 && prev_hs === 1'b0) rise1 = ncyc - t0;
         if (blank_rise >= 0 && blank_rise2 < 0 && d_blank_n === 1'b1) blank_cnt++;
         if (d_vs !== 1'b1) vs_low++;
         prev_hs = d_hs;
         prev_blank = d_blank_n;
      end
      checks++;
      if (blank_rise !== 807) begin
         errors++; $display("FAIL line1_blank_rise: got %0d expected 807", blank_rise);
      end
      checks++;
      if (fall1 - blank_rise !== 656) begin
         errors++; $display("FAIL hs_offset: got %0d expected 656", fall1 - blank_rise);
      end
      checks++;
      if (rise1 - fall1 !== 96) begin
         errors++; $display("FAIL hs_width: got %0d expected 96", rise1 - fall1);
      end
      checks++;
      if (fall2 - fall1 !== 800) begin
         errors++; $display("FAIL hs_period: got %0d expected 800", fall2 - fall1);
      end
      checks++;
      if (blank_cnt !== 640) begin
         errors++; $display("FAIL blank_width: got %0d expected 640", blank_cnt);
      end
      checks++;
      if (vs_low !== 0) begin
         errors++; $display("FAIL vs_early: got %0d low cycles expected 0", vs_low);
      end
   endtask

   task automatic test_alignment();
      int req_bad, dac_bad, rgb_bad, first_d;
      logic [26:0] got_v, exp_v;
      req_bad = 0; dac_bad = 0; rgb_bad = 0; first_d = -1;
      got_v = '0; exp_v = '0;
      repeat (1700) begin
         tick();
         if (d_req_v !== exp_req(G_D, ncyc - t0)) req_bad++;
         if (d_dac_v !== exp_dac(G_D, ncyc - t0)) begin
            if (dac_bad == 0) begin
               first_d = ncyc - t0; got_v = d_dac_v; exp_v = exp_dac(G_D, ncyc - t0);
            end
            dac_bad++;
         end
         if (d_blank_n === 1'b0 && {d_r, d_g, d_b} !== 24'd0) rgb_bad++;
      end
      checks++;
      if (req_bad !== 0) begin
         errors++; $display("FAIL align_req: got %0d bad cycles expected 0", req_bad);
      end
      checks++;
      if (dac_bad !== 0) begin
         errors++; $display("FAIL align_dac: got %0d bad cycles (first d=%0d got %h expected %h) expected 0", dac_bad, first_d, got_v, exp_v);
      end
      checks++;
      if (rgb_bad !== 0) begin
         errors++; $display("FAIL rgb_in_blank: got %0d cycles expected 0", rgb_bad);
      end
   endtask

   task automatic test_frame_small();
      int req_bad, dac_bad, vsf1, vsf2, vsr1, fs1, fs2, req_cnt, ls_cnt;
      logic prev_vs;
      req_bad = 0; dac_bad = 0; vsf1 = -1; vsf2 = -1; vsr1 = -1; fs1 = -1; fs2 = -1;
      req_cnt = 0; ls_cnt = 0;
      prev_vs = s_vs;
      repeat (560) begin
         tick();
         if (s_req_v !== exp_req(G_S, ncyc - t0)) req_bad++;
         if (s_dac_v !== exp_dac(G_S, ncyc - t0)) dac_bad++;
         if (s_vs === 1'b0 && prev_vs === 1'b1) begin
            if (vsf1 < 0) vsf1 = ncyc;
            else if (vsf2 < 0) vsf2 = ncyc;
         end
         if (vsf1 >= 0 && vsr1 < 0 && s_vs === 1'b1 && prev_vs === 1'b0) vsr1 = ncyc;
         if (s_fs === 1'b1) begin
            if (fs1 < 0) fs1 = ncyc;
            else if (fs2 < 0) fs2 = ncyc;
         end
         if (fs1 >= 0 && fs2 < 0) begin
            if (s_pix_req === 1'b1) req_cnt++;
            if (s_ls === 1'b1) ls_cnt++;
         end
         prev_vs = s_vs;
      end
      checks++;
      if (req_bad !== 0 || dac_bad !== 0) begin
         errors++; $display("FAIL small_frames: got %0d/%0d bad cycles expected 0/0", req_bad, dac_bad);
      end
      checks++;
      if (vsr1 - vsf1 !== 30) begin
         errors++; $display("FAIL small_vs_width: got %0d expected 30", vsr1 - vsf1);
      end
      checks++;
      if (vsf2 - vsf1 !== 165) begin
         errors++; $display("FAIL small_vs_period: got %0d expected 165", vsf2 - vsf1);
      end
      checks++;
      if (fs2 - fs1 !== 165) begin
         errors++; $display("FAIL small_frame_period: got %0d expected 165", fs2 - fs1);
      end
      checks++;
      if (req_cnt !== 48 || ls_cnt !== 6) begin
         errors++; $display("FAIL small_counts: got %0d req/%0d line_start expected 48/6", req_cnt, ls_cnt);
      end
   endtask

   task automatic test_lock_drop();
      int found, bad, d_bad, s_bad, d_fs1, s_fs1, s_fs2;
      found = 0;
      for (int k = 0; k < 900; k++) begin
         tick();
         if (((ncyc - t0 - 4) % 800) == 300) begin
            found = 1;
            break;
         end
      end
      checks++;
      if (found !== 1 || d_pix_x !== 10'd300 || d_pix_req !== 1'b1) begin
         errors++; $display("FAIL drop_position: got found=%0d x=%0d expected 1/300", found, d_pix_x);
      end
      pll_locked = 1'b0;
      repeat (3) tick();
      checks++;
      if (d_req_v !== 23'd0 || d_dac_v !== IDLE_DAC) begin
         errors++; $display("FAIL drop_idle: got %h/%h expected %h/%h", d_req_v, d_dac_v, 23'd0, IDLE_DAC);
      end
      checks++;
      if (s_req_v !== 23'd0 || s_dac_v !== IDLE_DAC) begin
         errors++; $display("FAIL drop_idle_small: got %h/%h expected %h/%h", s_req_v, s_dac_v, 23'd0, IDLE_DAC);
      end
      bad = 0;
      repeat (10) begin
         tick();
         if (d_req_v !== 23'd0 || d_dac_v !== IDLE_DAC) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL drop_hold: got %0d active cycles expected 0", bad);
      end
      pll_locked = 1'b1;
      t0 = ncyc;
      d_bad = 0; s_bad = 0; d_fs1 = -1; s_fs1 = -1; s_fs2 = -1;
      repeat (360) begin
         tick();
         if (d_req_v !== exp_req(G_D, ncyc - t0) || d_dac_v !== exp_dac(G_D, ncyc - t0)) d_bad++;
         if (s_req_v !== exp_req(G_S, ncyc - t0) || s_dac_v !== exp_dac(G_S, ncyc - t0)) s_bad++;
         if (d_fs === 1'b1 && d_fs1 < 0) d_fs1 = ncyc - t0;
         if (s_fs === 1'b1) begin
            if (s_fs1 < 0) s_fs1 = ncyc - t0;
            else if (s_fs2 < 0) s_fs2 = ncyc - t0;
         end
      end
      checks++;
      if (d_fs1 !== 4) begin
         errors++; $display("FAIL relock_frame_start: got %0d expected 4", d_fs1);
      end
      checks++;
      if (d_bad !== 0) begin
         errors++; $display("FAIL relock_stream: got %0d bad cycles expected 0", d_bad);
      end
      checks++;
      if (s_bad !== 0 || s_fs1 !== 4 || s_fs2 !== 169) begin
         errors++; $display("FAIL relock_small_frame: got %0d bad, fs %0d/%0d expected 0, 4/169", s_bad, s_fs1, s_fs2);
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if (d_req_v !== 23'd0 || d_dac_v !== IDLE_DAC || s_req_v !== 23'd0) begin
         errors++; $display("FAIL reset_mid_idle: got %h/%h expected %h/%h", d_req_v, d_dac_v, 23'd0, IDLE_DAC);
      end
      rst_n = 1'b1;
      t0 = ncyc;
      bad = 0;
      repeat (200) begin
         tick();
         if (d_req_v !== exp_req(G_D, ncyc - t0) || d_dac_v !== exp_dac(G_D, ncyc - t0)) bad++;
         if (s_req_v !== exp_req(G_S, ncyc - t0) || s_dac_v !== exp_dac(G_S, ncyc - t0)) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL reset_mid_restart: got %0d bad cycles expected 0", bad);
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected summary");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      pll_locked = 1'b0;
      test_reset();
      test_startup();
      test_line_timing();
      test_alignment();
      test_frame_small();
      test_lock_drop();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
